// File: rtl/ucode_arb_pkg.sv
// Shared definitions for the uCode memory arbiter and its CPU client:
// FSM encodings, port indices, default geometry and the boot image words.
package ucode_arb_pkg;

  localparam int DEF_DATA_SZ = 16;
  localparam int DEF_ADDR_SZ = 8;

  localparam int PORT_CPU  = 0;
  localparam int PORT_HOST = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } arb_state_e;

  // Boot image: NOP at 0x00, then a JMP back to 0x0000 so the CPU spins until the host loads code
  localparam logic [15:0] BOOT_NOP    = 16'h0000;
  localparam logic [15:0] BOOT_JMP    = 16'h8080;
  localparam logic [15:0] BOOT_TARGET = 16'h0000;

  function automatic logic [1:0] owner_code(arb_state_e s);
    case (s)
      ST_OWN0: return 2'b10;
      ST_OWN1: return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/ucode_ram.sv
// Single-port uCode RAM: one write or one read per cycle, registered read data,
// powered up with the boot image.
module ucode_ram
  import ucode_arb_pkg::*;
#(
  parameter int DATA_SZ = DEF_DATA_SZ,
  parameter int ADDR_SZ = DEF_ADDR_SZ
) (
  input  logic               i_clk,
  input  logic               i_we,
  input  logic               i_re,
  input  logic [ADDR_SZ-1:0] i_addr,
  input  logic [DATA_SZ-1:0] i_wdata,
  output logic [DATA_SZ-1:0] o_rdata
);

  localparam int DEPTH = 2 ** ADDR_SZ;

  logic [DATA_SZ-1:0] r_mem [DEPTH] = '{
    0: DATA_SZ'(BOOT_NOP),
    1: DATA_SZ'(BOOT_JMP),
    2: DATA_SZ'(BOOT_TARGET),
    default: {DATA_SZ{1'b0}}
  };
  logic [DATA_SZ-1:0] r_rdata;

  // No reset here so the array maps onto block RAM and survives arbiter resets
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end else if (i_re) begin
      r_rdata <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/ucode_arb.sv
// Two-port arbiter (CPU on port 0, host loader/debug on port 1) in front of the
// single-port uCode RAM, with round-robin on contention and per-port locking.
module ucode_arb
  import ucode_arb_pkg::*;
#(
  parameter int DATA_SZ = DEF_DATA_SZ,
  parameter int ADDR_SZ = DEF_ADDR_SZ
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_req0,
  input  logic               i_wr0,
  input  logic [ADDR_SZ-1:0] i_addr0,
  input  logic [DATA_SZ-1:0] i_wdata0,
  input  logic               i_lock0,
  output logic               o_ack0,
  output logic               o_rvalid0,
  output logic [DATA_SZ-1:0] o_rdata0,
  input  logic               i_req1,
  input  logic               i_wr1,
  input  logic [ADDR_SZ-1:0] i_addr1,
  input  logic [DATA_SZ-1:0] i_wdata1,
  input  logic               i_lock1,
  output logic               o_ack1,
  output logic               o_rvalid1,
  output logic [DATA_SZ-1:0] o_rdata1,
  output logic [1:0]         o_owner
);

  arb_state_e         r_state;
  logic               r_ptr;
  logic [1:0]         r_owner;
  logic               r_rvalid0;
  logic               r_rvalid1;
  logic [DATA_SZ-1:0] r_hold0;
  logic [DATA_SZ-1:0] r_hold1;

  logic               w_ack0;
  logic               w_ack1;
  logic               w_we;
  logic               w_re;
  logic [ADDR_SZ-1:0] w_addr;
  logic [DATA_SZ-1:0] w_wdata;
  logic [DATA_SZ-1:0] w_q;

  // r_ptr is the last granted port; contention goes to the other one
  always_comb begin
    w_ack0 = 1'b0;
    w_ack1 = 1'b0;
    if (!i_rst) begin
      case (r_state)
        ST_OWN0: w_ack0 = i_req0;
        ST_OWN1: w_ack1 = i_req1;
        default: begin
          if (i_req0 && i_req1) begin
            w_ack0 = r_ptr;
            w_ack1 = ~r_ptr;
          end else begin
            w_ack0 = i_req0;
            w_ack1 = i_req1;
          end
        end
      endcase
    end
  end

  assign w_addr  = w_ack1 ? i_addr1  : i_addr0;
  assign w_wdata = w_ack1 ? i_wdata1 : i_wdata0;
  assign w_we    = (w_ack0 & i_wr0)  | (w_ack1 & i_wr1);
  assign w_re    = (w_ack0 & ~i_wr0) | (w_ack1 & ~i_wr1);

  ucode_ram #(
    .DATA_SZ(DATA_SZ),
    .ADDR_SZ(ADDR_SZ)
  ) u_ram (
    .i_clk  (i_clk),
    .i_we   (w_we),
    .i_re   (w_re),
    .i_addr (w_addr),
    .i_wdata(w_wdata),
    .o_rdata(w_q)
  );

  // A lock is released on the first edge with the owner's lock low, access or not
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_owner <= owner_code(ST_IDLE);
      r_ptr   <= 1'(PORT_HOST);
    end else begin
      if (w_ack0) begin
        r_ptr <= 1'(PORT_CPU);
      end else if (w_ack1) begin
        r_ptr <= 1'(PORT_HOST);
      end
      case (r_state)
        ST_IDLE: begin
          if (w_ack0 && i_lock0) begin
            r_state <= ST_OWN0;
            r_owner <= owner_code(ST_OWN0);
          end else if (w_ack1 && i_lock1) begin
            r_state <= ST_OWN1;
            r_owner <= owner_code(ST_OWN1);
          end
        end
        ST_OWN0: begin
          if (!i_lock0) begin
            r_state <= ST_IDLE;
            r_owner <= owner_code(ST_IDLE);
          end
        end
        ST_OWN1: begin
          if (!i_lock1) begin
            r_state <= ST_IDLE;
            r_owner <= owner_code(ST_IDLE);
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_owner <= owner_code(ST_IDLE);
        end
      endcase
    end
  end

  // RAM output is shown during the valid cycle, then held per port until its next read
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;
      r_hold0   <= '0;
      r_hold1   <= '0;
    end else begin
      r_rvalid0 <= w_ack0 & ~i_wr0;
      r_rvalid1 <= w_ack1 & ~i_wr1;
      if (r_rvalid0) begin
        r_hold0 <= w_q;
      end
      if (r_rvalid1) begin
        r_hold1 <= w_q;
      end
    end
  end

  assign o_ack0    = w_ack0;
  assign o_ack1    = w_ack1;
  assign o_rvalid0 = r_rvalid0;
  assign o_rvalid1 = r_rvalid1;
  assign o_rdata0  = r_rvalid0 ? w_q : r_hold0;
  assign o_rdata1  = r_rvalid1 ? w_q : r_hold1;
  assign o_owner   = r_owner;

endmodule

// File: tb/tb_ucode_arb.sv
// Bench for ucode_arb: a behavioural model (memory array, lock holder, last grant)
// is compared against the DUT every cycle, plus hand-computed literal expectations.
module tb_ucode_arb;

  localparam int DW = 16;
  localparam int AW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic          req   [2];
  logic          wr    [2];
  logic          lock  [2];
  logic [AW-1:0] addr  [2];
  logic [DW-1:0] wdata [2];

  logic          ack0, ack1, rv0, rv1;
  logic [DW-1:0] rd0, rd1;
  logic [1:0]    owner;

  int nChecks = 0;
  int nPass   = 0;
  bit compareEn = 1'b0;

  // Model state: memory contents, current lock holder (-1 none), last granted port
  logic [DW-1:0] mdlMem [256];
  int            holder  = -1;
  int            lastGnt = 1;
  bit            expRv [2];
  logic [DW-1:0] expRd [2];

  always #5 clk = ~clk;

  ucode_arb #(.DATA_SZ(DW), .ADDR_SZ(AW)) dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_req0   (req[0]),
    .i_wr0    (wr[0]),
    .i_addr0  (addr[0]),
    .i_wdata0 (wdata[0]),
    .i_lock0  (lock[0]),
    .o_ack0   (ack0),
    .o_rvalid0(rv0),
    .o_rdata0 (rd0),
    .i_req1   (req[1]),
    .i_wr1    (wr[1]),
    .i_addr1  (addr[1]),
    .i_wdata1 (wdata[1]),
    .i_lock1  (lock[1]),
    .o_ack1   (ack1),
    .o_rvalid1(rv1),
    .o_rdata1 (rd1),
    .o_owner  (owner)
  );

  task automatic checkOutput(string name, logic [31:0] act, logic [31:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
  endtask

  // Who may be acked right now, from the arbitration rules alone
  function automatic bit expAck(int p);
    if (rst) return 1'b0;
    if (holder >= 0) return (p == holder) && (req[p] === 1'b1);
    if (req[0] === 1'b1 && req[1] === 1'b1) return p != lastGnt;
    return req[p] === 1'b1;
  endfunction

  function automatic logic [1:0] expOwner();
    if (holder < 0) return 2'b00;
    return (holder == 1) ? 2'b11 : 2'b10;
  endfunction

  always @(posedge clk or posedge rst) begin
    int g;
    if (rst) begin
      holder   = -1;
      lastGnt  = 1;
      expRv[0] = 1'b0;
      expRv[1] = 1'b0;
      expRd[0] = '0;
      expRd[1] = '0;
    end else begin
      g = -1;
      if (expAck(0)) g = 0;
      else if (expAck(1)) g = 1;
      expRv[0] = 1'b0;
      expRv[1] = 1'b0;
      if (g >= 0) begin
        if (wr[g]) mdlMem[addr[g]] = wdata[g];
        else begin
          expRv[g] = 1'b1;
          expRd[g] = mdlMem[addr[g]];
        end
        lastGnt = g;
      end
      if (holder >= 0) begin
        if (!lock[holder]) holder = -1;
      end else if (g >= 0 && lock[g]) begin
        holder = g;
      end
    end
  end

  always @(negedge clk) begin
    if (compareEn) begin
      checkOutput("mdl_ack0",    32'(ack0),  32'(expAck(0)));
      checkOutput("mdl_ack1",    32'(ack1),  32'(expAck(1)));
      checkOutput("mdl_rvalid0", 32'(rv0),   32'(expRv[0]));
      checkOutput("mdl_rvalid1", 32'(rv1),   32'(expRv[1]));
      checkOutput("mdl_rdata0",  32'(rd0),   32'(expRd[0]));
      checkOutput("mdl_rdata1",  32'(rd1),   32'(expRd[1]));
      checkOutput("mdl_owner",   32'(owner), 32'(expOwner()));
    end
  end

  task automatic applyStimulus(int p, logic r, logic w, logic [AW-1:0] a, logic [DW-1:0] d, logic l);
    req[p]   = r;
    wr[p]    = w;
    addr[p]  = a;
    wdata[p] = d;
    lock[p]  = l;
  endtask

  task automatic idle(int p);
    applyStimulus(p, 1'b0, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, checks so far %0d", nChecks);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    idle(0);
    idle(1);
    for (int i = 0; i < 256; i++) mdlMem[i] = '0;
    mdlMem[1] = 16'h8080;

    @(posedge clk);
    #1;
    compareEn = 1'b1;
    checkOutput("rst_ack0",    32'(ack0),  0);
    checkOutput("rst_rvalid0", 32'(rv0),   0);
    checkOutput("rst_rdata0",  32'(rd0),   0);
    checkOutput("rst_owner",   32'(owner), 0);
    step();
    rst = 1'b0;

    // Port 0 reads the JMP opcode alone
    applyStimulus(0, 1'b1, 1'b0, 8'h01, '0, 1'b0);
    #1 checkOutput("boot_ack0", 32'(ack0), 1);
    step();
    idle(0);
    #1;
    checkOutput("boot_rvalid0", 32'(rv0), 1);
    checkOutput("boot_rdata0",  32'(rd0), 'h8080);
    step();
    checkOutput("boot_rvalid0_off", 32'(rv0), 0);
    checkOutput("boot_rdata0_hold", 32'(rd0), 'h8080);

    // Contention right after reset alternates 0,1,0,1
    doReset();
    applyStimulus(0, 1'b1, 1'b0, 8'h00, '0, 1'b0);
    applyStimulus(1, 1'b1, 1'b0, 8'h01, '0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      #1;
      checkOutput("rr_ack0", 32'(ack0), (k % 2 == 0) ? 1 : 0);
      checkOutput("rr_ack1", 32'(ack1), (k % 2 == 1) ? 1 : 0);
      step();
    end
    #1 checkOutput("rr_rdata1", 32'(rd1), 'h8080);
    idle(0);
    idle(1);
    step();

    // Host write then CPU read of the same word
    applyStimulus(1, 1'b1, 1'b1, 8'h40, 16'hBEEF, 1'b0);
    #1 checkOutput("wr_ack1", 32'(ack1), 1);
    step();
    idle(1);
    applyStimulus(0, 1'b1, 1'b0, 8'h40, '0, 1'b0);
    #1;
    checkOutput("wr_ack0", 32'(ack0), 1);
    checkOutput("wr_no_rvalid1", 32'(rv1), 0);
    step();
    idle(0);
    #1 checkOutput("wr_rdata0", 32'(rd0), 'hBEEF);
    step();

    // Top address
    applyStimulus(1, 1'b1, 1'b1, 8'hFF, 16'hA5A5, 1'b0);
    step();
    idle(1);
    applyStimulus(0, 1'b1, 1'b0, 8'hFF, '0, 1'b0);
    step();
    idle(0);
    #1 checkOutput("top_rdata0", 32'(rd0), 'hA5A5);
    step();

    // Host locks for three writes while the CPU waits on a read of 0x12
    applyStimulus(1, 1'b1, 1'b1, 8'h10, 16'h1111, 1'b1);
    applyStimulus(0, 1'b1, 1'b0, 8'h12, '0, 1'b0);
    #1;
    checkOutput("lk_a_ack1", 32'(ack1), 1);
    checkOutput("lk_a_ack0", 32'(ack0), 0);
    step();
    applyStimulus(1, 1'b1, 1'b1, 8'h11, 16'h2222, 1'b1);
    #1;
    checkOutput("lk_b_ack0",  32'(ack0),  0);
    checkOutput("lk_b_owner", 32'(owner), 'b11);
    step();
    applyStimulus(1, 1'b1, 1'b1, 8'h12, 16'h3333, 1'b0);
    #1;
    checkOutput("lk_c_ack0",  32'(ack0),  0);
    checkOutput("lk_c_owner", 32'(owner), 'b11);
    step();
    idle(1);
    #1;
    checkOutput("lk_d_ack0",  32'(ack0),  1);
    checkOutput("lk_d_owner", 32'(owner), 0);
    step();
    idle(0);
    #1 checkOutput("lk_rdata0", 32'(rd0), 'h3333);
    step();

    // A CPU write withdrawn during a host lock leaves no trace
    applyStimulus(1, 1'b1, 1'b0, 8'h10, '0, 1'b1);
    step();
    applyStimulus(1, 1'b0, 1'b0, '0, '0, 1'b1);
    applyStimulus(0, 1'b1, 1'b1, 8'h31, 16'hDEAD, 1'b0);
    #1;
    checkOutput("drop_ack0",   32'(ack0),  0);
    checkOutput("drop_owner",  32'(owner), 'b11);
    checkOutput("drop_rdata1", 32'(rd1),   'h1111);
    step();
    idle(0);
    #1 checkOutput("hold_owner", 32'(owner), 'b11);
    step();
    idle(1);
    step();
    applyStimulus(0, 1'b1, 1'b0, 8'h31, '0, 1'b0);
    step();
    idle(0);
    #1 checkOutput("drop_rdata0", 32'(rd0), 0);
    step();

    // Reset while the host holds a lock
    applyStimulus(1, 1'b1, 1'b0, 8'h02, '0, 1'b1);
    step();
    applyStimulus(1, 1'b0, 1'b0, '0, '0, 1'b1);
    #1 checkOutput("rstlk_owner_pre", 32'(owner), 'b11);
    #1 rst = 1'b1;
    #1 checkOutput("rstlk_owner", 32'(owner), 0);
    step();
    step();
    rst = 1'b0;
    idle(1);

    // Reset lands in the cycle after a CPU read ack, with a host lock write pending
    applyStimulus(0, 1'b1, 1'b0, 8'h01, '0, 1'b0);
    applyStimulus(1, 1'b1, 1'b1, 8'h40, 16'h5555, 1'b1);
    #1 checkOutput("rr_rst_ack0", 32'(ack0), 1);
    step();
    idle(0);
    #1 checkOutput("rr_rst_ack1_pending", 32'(ack1), 1);
    #1 rst = 1'b1;
    #1;
    checkOutput("mid_rst_rvalid0", 32'(rv0),   0);
    checkOutput("mid_rst_owner",   32'(owner), 0);
    checkOutput("mid_rst_ack1",    32'(ack1),  0);
    checkOutput("mid_rst_rdata0",  32'(rd0),   0);
    step();
    rst = 1'b0;
    idle(1);
    step();
    applyStimulus(0, 1'b1, 1'b0, 8'h01, '0, 1'b0);
    step();
    idle(0);
    #1 checkOutput("post_rst_boot", 32'(rd0), 'h8080);
    step();
    applyStimulus(1, 1'b1, 1'b0, 8'h40, '0, 1'b0);
    step();
    idle(1);
    #1 checkOutput("post_rst_nowrite", 32'(rd1), 'hBEEF);
    step();
    step();

    compareEn = 1'b0;
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
